// File: rtl/ex_ex2_memhold_if.sv
// ex_ex2_memhold_if -- EX2 <-> L1 data-cache request/response bus.
//
//   dcOutAddr  [31:0]  request address                     (master -> slave)
//   dcOutOpm   [4:0]   request op, all-zero (READY) = idle  (master -> slave)
//   dcOutData  [63:0]  store data                          (master -> slave)
//   dcInData   [63:0]  load data, right-aligned            (slave -> master)
//   dcInOK     [1:0]   00=READY 01=OK 10=HOLD 11=FAULT     (slave -> master)
//
// master: the EX2 stage issuing requests; slave: the data cache.
interface ex_ex2_memhold_if;
    logic [31:0] dcOutAddr;
    logic [4:0]  dcOutOpm;
    logic [63:0] dcOutData;
    logic [63:0] dcInData;
    logic [1:0]  dcInOK;

    modport master (
        output dcOutAddr,
        output dcOutOpm,
        output dcOutData,
        input  dcInData,
        input  dcInOK
    );

    modport slave (
        input  dcOutAddr,
        input  dcOutOpm,
        input  dcOutData,
        output dcInData,
        output dcInOK
    );
endinterface

// File: rtl/ex_ex2_memhold.sv
// ex_ex2_memhold -- EX2 memory-completion stage.
//
// Latches the load/store request initiated by EX1, presents it to the L1
// data cache, stalls the pipeline until the cache answers, then produces a
// registered GPR writeback (extended load data) or a one-cycle fault pulse
// on cache FAULT / wait-counter timeout.
//
// Parameters:
//   TMO_BITS    width of the wait counter; timeout when it reaches all-ones
//
// Ports:
//   clock       core clock
//   reset       synchronous, active-high
//   memAddr     request address from EX1
//   memOpm      request op: [4:3] 01=load 10=store; [2] zero-ext; [1:0] size B/W/L/Q
//   memDataOut  store data from EX1
//   regIdRm     load destination GPR from EX1
//   exHold      stall request to EX1 and upstream
//   heldIdRn2   GPR with a load outstanding (interlock), null register otherwise
//   regIdRn2    registered writeback destination, null register when none
//   regValRn2   registered writeback value
//   exFault     one-cycle pulse on cache fault or timeout
//   dc          cache bus (master side)
module ex_ex2_memhold #(
    parameter int unsigned TMO_BITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      memAddr,
    input  logic [4:0]       memOpm,
    input  logic [63:0]      memDataOut,
    input  logic [5:0]       regIdRm,
    output logic             exHold,
    output logic [5:0]       heldIdRn2,
    output logic [5:0]       regIdRn2,
    output logic [63:0]      regValRn2,
    output logic             exFault,
    ex_ex2_memhold_if.master dc
);

    // Null register ID: "no register".
    localparam logic [5:0] JX2_GR_ZZR     = 6'h3F;
    localparam logic [4:0] UMEM_OPM_READY = 5'b00000;

    localparam logic [1:0] DC_OK    = 2'b01;
    localparam logic [1:0] DC_FAULT = 2'b11;

    localparam logic [1:0] OPC_LOAD  = 2'b01;
    localparam logic [1:0] OPC_STORE = 2'b10;

    localparam logic [TMO_BITS-1:0] TMO_LIMIT = '1;
    localparam logic [TMO_BITS-1:0] CNT_ONE   = TMO_BITS'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request registers; they also drive the cache bus directly.
    logic [31:0]         req_addr;
    logic [4:0]          req_opm;
    logic [63:0]         req_data;
    logic [5:0]          req_id;
    logic [TMO_BITS-1:0] wait_cnt;

    // Per-cycle actions decided by the FSM.
    logic capture;
    logic finish_ok;
    logic finish_err;
    logic cnt_step;

    logic        req_is_load;
    logic [63:0] load_ext;

    assign req_is_load = (req_opm[4:3] == OPC_LOAD);

    // Sign/zero extension of right-aligned load data. Quad ignores mode[2].
    function automatic logic [63:0] extend_load(input logic [2:0]  mode,
                                                input logic [63:0] raw);
        logic [63:0] res;
        res = raw;
        unique case (mode[1:0])
            2'b00:   res = mode[2] ? {56'd0, raw[7:0]}
                                   : {{56{raw[7]}}, raw[7:0]};
            2'b01:   res = mode[2] ? {48'd0, raw[15:0]}
                                   : {{48{raw[15]}}, raw[15:0]};
            2'b10:   res = mode[2] ? {32'd0, raw[31:0]}
                                   : {{32{raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign load_ext = extend_load(req_opm[2:0], dc.dcInData);

    // Cache bus: op is only visible while BUSY, so the cache sees READY for
    // at least one cycle between consecutive requests.
    assign dc.dcOutAddr = req_addr;
    assign dc.dcOutData = req_data;
    assign dc.dcOutOpm  = (state == BUSY) ? req_opm : UMEM_OPM_READY;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        exHold     = 1'b0;
        heldIdRn2  = JX2_GR_ZZR;
        capture    = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        cnt_step   = 1'b0;

        unique case (state)
            IDLE: begin
                if (memOpm[4:3] == OPC_LOAD || memOpm[4:3] == OPC_STORE) begin
                    capture   = 1'b1;
                    exHold    = 1'b1;
                    state_nxt = BUSY;
                    // Interlock must cover the capture cycle too, before the
                    // request registers hold the ID.
                    if (memOpm[4:3] == OPC_LOAD) begin
                        heldIdRn2 = regIdRm;
                    end
                end
            end
            BUSY: begin
                if (req_is_load) begin
                    heldIdRn2 = req_id;
                end
                // OK takes priority over fault/timeout in the same cycle.
                if (dc.dcInOK == DC_OK) begin
                    finish_ok = 1'b1;
                    state_nxt = IDLE;
                end else if (dc.dcInOK == DC_FAULT || wait_cnt == TMO_LIMIT) begin
                    finish_err = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    exHold   = 1'b1;
                    cnt_step = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_addr  <= '0;
            req_opm   <= UMEM_OPM_READY;
            req_data  <= '0;
            req_id    <= JX2_GR_ZZR;
            wait_cnt  <= '0;
            regIdRn2  <= JX2_GR_ZZR;
            regValRn2 <= '0;
            exFault   <= 1'b0;
        end else begin
            // Writeback and fault are single-cycle events.
            regIdRn2 <= JX2_GR_ZZR;
            exFault  <= 1'b0;

            if (capture) begin
                req_addr <= memAddr;
                req_opm  <= memOpm;
                req_data <= memDataOut;
                req_id   <= regIdRm;
                wait_cnt <= '0;
            end

            if (cnt_step && wait_cnt != TMO_LIMIT) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end

            if (finish_ok && req_is_load) begin
                regIdRn2  <= req_id;
                regValRn2 <= load_ext;
            end

            if (finish_err) begin
                exFault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_ex2_memhold.sv
// Testbench for ex_ex2_memhold: directed load/store sequences against a
// scripted cache; writebacks and fault pulses are checked by a scoreboard.
module tb_ex_ex2_memhold;

    localparam logic [5:0] ZZR      = 6'h3F;
    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_OK    = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] memAddr;
    logic [4:0]  memOpm;
    logic [63:0] memDataOut;
    logic [5:0]  regIdRm;
    logic        exHold;
    logic [5:0]  heldIdRn2;
    logic [5:0]  regIdRn2;
    logic [63:0] regValRn2;
    logic        exFault;

    ex_ex2_memhold_if dc();

    ex_ex2_memhold #(.TMO_BITS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .memAddr    (memAddr),
        .memOpm     (memOpm),
        .memDataOut (memDataOut),
        .regIdRm    (regIdRm),
        .exHold     (exHold),
        .heldIdRn2  (heldIdRn2),
        .regIdRn2   (regIdRn2),
        .regValRn2  (regValRn2),
        .exFault    (exFault),
        .dc         (dc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        is_fault;
        logic [5:0]  id;
        logic [63:0] val;
    } evt_t;

    evt_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic is_fault, input logic [5:0] id, input logic [63:0] val);
        evt_t e;
        e.is_fault = is_fault;
        e.id       = id;
        e.val      = val;
        exp_q.push_back(e);
    endtask

    // Monitor: any writeback or fault pulse must match the next expected event.
    always @(negedge clock) begin
        if (mon_en && (regIdRn2 !== ZZR || exFault !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got id=%h val=%h fault=%b expected no output",
                         regIdRn2, regValRn2, exFault);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                chk("mon_fault", 64'(exFault), 64'(e.is_fault));
                chk("mon_id", 64'(regIdRn2), e.is_fault ? 64'(ZZR) : 64'(e.id));
                if (!e.is_fault) begin
                    chk("mon_val", regValRn2, e.val);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // One complete request: capture cycle, n_hold waiting cycles, then a
    // terminating cycle with last_st (OK, FAULT, or HOLD for a timeout).
    task automatic run_op(input string name, input logic [4:0] opm, input logic [31:0] addr,
                          input logic [63:0] sdata, input logic [5:0] id, input int n_hold,
                          input logic [1:0] last_st, input logic [63:0] rdata,
                          input logic [63:0] exp_val);
        logic is_load;
        is_load    = (opm[4:3] == 2'b01);
        memOpm     = opm;
        memAddr    = addr;
        memDataOut = sdata;
        regIdRm    = id;
        dc.dcInOK  = ST_READY;
        dc.dcInData = '0;
        @(negedge clock);
        chk({name, "_cap_hold"}, 64'(exHold), 64'd1);
        chk({name, "_cap_held"}, 64'(heldIdRn2), is_load ? 64'(id) : 64'(ZZR));
        chk({name, "_cap_opm"}, 64'(dc.dcOutOpm), 64'd0);
        next_cycle();
        for (int i = 0; i < n_hold; i++) begin
            dc.dcInOK = ST_HOLD;
            @(negedge clock);
            chk({name, "_wait_hold"}, 64'(exHold), 64'd1);
            chk({name, "_wait_opm"}, 64'(dc.dcOutOpm), 64'(opm));
            chk({name, "_wait_addr"}, 64'(dc.dcOutAddr), 64'(addr));
            chk({name, "_wait_held"}, 64'(heldIdRn2), is_load ? 64'(id) : 64'(ZZR));
            if (!is_load) begin
                chk({name, "_wait_data"}, dc.dcOutData, sdata);
            end
            next_cycle();
        end
        dc.dcInOK   = last_st;
        dc.dcInData = rdata;
        @(negedge clock);
        chk({name, "_end_hold"}, 64'(exHold), 64'd0);
        chk({name, "_end_opm"}, 64'(dc.dcOutOpm), 64'(opm));
        chk({name, "_end_addr"}, 64'(dc.dcOutAddr), 64'(addr));
        if (!is_load) begin
            chk({name, "_end_data"}, dc.dcOutData, sdata);
        end
        if (last_st == ST_OK) begin
            if (is_load) begin
                push_evt(1'b0, id, exp_val);
            end
        end else begin
            push_evt(1'b1, ZZR, 64'd0);
        end
        next_cycle();
        memOpm      = '0;
        dc.dcInOK   = ST_READY;
        dc.dcInData = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        memAddr     = '0;
        memOpm      = '0;
        memDataOut  = '0;
        regIdRm     = '0;
        dc.dcInData = '0;
        dc.dcInOK   = ST_READY;
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk("rst_hold", 64'(exHold), 64'd0);
        chk("rst_held", 64'(heldIdRn2), 64'(ZZR));
        chk("rst_id", 64'(regIdRn2), 64'(ZZR));
        chk("rst_val", regValRn2, 64'd0);
        chk("rst_fault", 64'(exFault), 64'd0);
        chk("rst_opm", 64'(dc.dcOutOpm), 64'd0);
        chk("rst_addr", 64'(dc.dcOutAddr), 64'd0);
        chk("rst_data", dc.dcOutData, 64'd0);
        next_cycle();
        reset  = 1'b0;
        mon_en = 1'b1;
        next_cycle();

        // Byte signed, OK on first BUSY cycle.
        run_op("ldb_s", 5'b01000, 32'h0000_1000, 64'd0, 6'd5, 0, ST_OK,
               64'h1234_5678_1234_5680, 64'hFFFF_FFFF_FFFF_FF80);
        // Word zero-extended after three HOLDs.
        run_op("ldw_z", 5'b01101, 32'h0000_2002, 64'd0, 6'd12, 3, ST_OK,
               64'h0000_0000_FFFF_8001, 64'h0000_0000_0000_8001);
        // Store quad.
        run_op("stq", 5'b10011, 32'h0000_3008, 64'h0123_4567_89AB_CDEF, 6'd3, 1, ST_OK,
               64'd0, 64'd0);
        // Timeout: HOLD forever, counter limit 15 reached on 16th BUSY cycle.
        run_op("tmo", 5'b01010, 32'h0000_4000, 64'd0, 6'd20, 15, ST_HOLD,
               64'd0, 64'd0);
        @(negedge clock);
        chk("tmo_idle_opm", 64'(dc.dcOutOpm), 64'd0);
        chk("tmo_idle_hold", 64'(exHold), 64'd0);
        next_cycle();
        // FAULT on second BUSY cycle, then loads back-to-back.
        run_op("flt", 5'b01000, 32'h0000_5000, 64'd0, 6'd7, 1, ST_FAULT,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        run_op("ldq", 5'b01011, 32'h0000_5008, 64'd0, 6'd8, 0, ST_OK,
               64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210);
        run_op("ldl_s", 5'b01010, 32'h0000_5010, 64'd0, 6'd9, 2, ST_OK,
               64'h1111_1111_8000_0001, 64'hFFFF_FFFF_8000_0001);
        run_op("ldw_s", 5'b01001, 32'h0000_5018, 64'd0, 6'd10, 0, ST_OK,
               64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001);
        run_op("ldb_z", 5'b01100, 32'h0000_5020, 64'd0, 6'd11, 0, ST_OK,
               64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080);
        run_op("ldq_z", 5'b01111, 32'h0000_5028, 64'd0, 6'd1, 0, ST_OK,
               64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        run_op("ldl_z", 5'b01110, 32'h0000_5030, 64'd0, 6'd2, 0, ST_OK,
               64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000);

        // Op class 11 is ignored.
        memOpm  = 5'b11000;
        regIdRm = 6'd4;
        @(negedge clock);
        chk("op11_hold", 64'(exHold), 64'd0);
        chk("op11_held", 64'(heldIdRn2), 64'(ZZR));
        next_cycle();
        memOpm = '0;
        @(negedge clock);
        chk("op11_opm", 64'(dc.dcOutOpm), 64'd0);
        next_cycle();

        // Reset mid-BUSY on a held load.
        memOpm     = 5'b01000;
        memAddr    = 32'h0000_6000;
        memDataOut = 64'hAAAA_5555_AAAA_5555;
        regIdRm    = 6'd13;
        next_cycle();
        dc.dcInOK = ST_HOLD;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset       = 1'b0;
        memOpm      = '0;
        dc.dcInOK   = ST_OK;
        dc.dcInData = 64'h0000_0000_0000_0042;
        @(negedge clock);
        chk("mrst_hold", 64'(exHold), 64'd0);
        chk("mrst_held", 64'(heldIdRn2), 64'(ZZR));
        chk("mrst_id", 64'(regIdRn2), 64'(ZZR));
        chk("mrst_val", regValRn2, 64'd0);
        chk("mrst_fault", 64'(exFault), 64'd0);
        chk("mrst_opm", 64'(dc.dcOutOpm), 64'd0);
        chk("mrst_addr", 64'(dc.dcOutAddr), 64'd0);
        chk("mrst_data", dc.dcOutData, 64'd0);
        next_cycle();
        dc.dcInOK = ST_READY;
        repeat (4) next_cycle();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_ex2_memhold.md
Name: ex_ex2_memhold

Overview:
EX2 memory-completion stage, directly downstream of EX1. EX1 only initiates a load/store (memAddr/memOpm/memDataOut plus held destination ID).
- This block latches that request and drives it to the L1 data cache.
- Holds the pipeline until the cache acknowledges.
- Extends load data and presents a registered GPR writeback to the next stage.
- Detects cache faults and request timeouts.

Parameters:
TMO_BITS, 8, width of the wait-cycle counter; timeout fires when the counter reaches 2^TMO_BITS-1.

Ports:
clock  in  1  core clock
reset  in  1  reset, synchronous, active-high
memAddr  in  32  request address from EX1
memOpm  in  5  request op from EX1: [4:3] 01=load, 10=store, 00=none; [2] 1=zero-extend, 0=sign-extend; [1:0] size 00=B, 01=W, 10=L, 11=Q
memDataOut  in  64  store data from EX1
regIdRm  in  6  load destination GPR from EX1
exHold  out  1  stall request to EX1 and upstream
heldIdRn2  out  6  GPR with a load outstanding, for interlock; JX2_GR_ZZR otherwise
regIdRn2  out  6  writeback destination (registered)
regValRn2  out  64  writeback value (registered)
exFault  out  1  one-cycle pulse: cache fault or timeout
dcOutAddr  out  32  cache request address
dcOutOpm  out  5  cache request op; UMEM_OPM_READY when idle
dcOutData  out  64  cache store data
dcInData  in  64  cache load data, right-aligned
dcInOK  in  2  cache status: 00=READY, 01=OK, 10=HOLD, 11=FAULT

Behaviour:
Reset values (synchronous reset, active-high):
- State IDLE; exHold=0; heldIdRn2=JX2_GR_ZZR.
- regIdRn2=JX2_GR_ZZR; regValRn2=0; exFault=0.
- dcOutOpm=UMEM_OPM_READY; dcOutAddr=0; dcOutData=0; counter=0.

State IDLE:
- If memOpm[4:3] is 01 or 10, latch addr/opm/data/regIdRm into request registers, clear the counter, go to BUSY, and assert exHold=1 that cycle.
- Otherwise (memOpm[4:3] of 00 or 11) do nothing; exHold=0.

State BUSY:
- dcOut* are driven from the request registers, so the cache sees the op the cycle after capture.
- exHold=1, except in the cycle dcInOK==OK.
- dcInOK==OK: go to IDLE. For a load, next cycle regIdRn2=latched ID and regValRn2=extended dcInData. For a store, regIdRn2 stays ZZR.
- dcInOK==HOLD or READY: stay in BUSY; counter increments, saturating.
- dcInOK==FAULT, or counter==2^TMO_BITS-1: go to IDLE; exFault=1 next cycle for exactly one cycle; no writeback; exHold released that cycle.

Registered outputs and interlock:
- regIdRn2 defaults to ZZR every cycle; it is non-ZZR for exactly one cycle per completed load.
- heldIdRn2 is combinational: the latched ID while in BUSY with a load; ZZR otherwise (including IDLE capture cycle? no—see next point).
- In the IDLE capture cycle of a load, heldIdRn2=regIdRm.

Load extension:
- B: bit 7 replicated, or zero-extended if opm[2]=1.
- W: bit 15 replicated or zero-extended.
- L: bit 31 replicated or zero-extended.
- Q: passthrough; opm[2] ignored.

Timing and boundary conditions:
- Minimum latency: op presented at cycle N; cache request at N+1; OK at N+1 gives writeback valid at N+2; exHold is high only at N.
- Back-to-back ops: the next op presented in the cycle after OK is captured normally.
- Cache sees dcOutOpm=READY for one cycle between requests.
- Reset mid-BUSY: next cycle is IDLE with dcOutOpm=READY; the pending load is never written back and exFault stays 0.
- OK and counter saturation in the same cycle: OK wins.

Test Plan:
1. Load byte, signed: memOpm=01_0_00, addr=0x1000, regIdRm=5; cache OK on first BUSY cycle with dcInData=0x..80 -> exHold high 1 cycle; regIdRn2=5 and regValRn2=0xFFFFFFFFFFFFFF80 at N+2 for exactly one cycle.
2. Load word, zero-extend: opm=01_1_01, dcInData=0xFFFF_8001, 3 HOLD cycles then OK -> exHold high 4 cycles; heldIdRn2=ID throughout; regValRn2=0x8001.
3. Store quad: opm=10_0_11, data=0x0123456789ABCDEF -> dcOutOpm/dcOutData match on cycles N+1..OK; regIdRn2 stays ZZR.
4. Timeout: TMO_BITS=4, cache returns HOLD forever -> exHold releases after 16 BUSY cycles; exFault pulses once; no writeback; dcOutOpm returns to READY.
5. FAULT response: dcInOK=11 on second BUSY cycle -> exFault pulses 1 cycle; regIdRn2=ZZR; next op accepted immediately.
6. Reset asserted mid-BUSY during a load with HOLD -> next cycle all outputs at reset values; no writeback appears afterwards.
